// File: rtl/cpu_pkg.sv
// Shared decoder definitions: field widths, opcode constants, FSM state
// encoding and the instruction classifier used by instruction_decoder.
package cpu_pkg;

  localparam int PM_W   = 8;
  localparam int SEL_W  = 3;
  localparam int ADDR_W = 4;

  // High-nibble opcodes for the two jump forms
  localparam logic [3:0] OP_JMP = 4'hE;
  localparam logic [3:0] OP_JNZ = 4'hF;

  // Opcodes inside the ALU range that are treated as NOP strobes
  localparam logic [7:0] OP_NOPC8 = 8'hC8;
  localparam logic [7:0] OP_NOPCF = 8'hCF;
  localparam logic [7:0] OP_NOPD8 = 8'hD8;
  localparam logic [7:0] OP_NOPDF = 8'hDF;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } dec_state_t;

  typedef enum logic [2:0] {
    CL_LOAD = 3'd0,
    CL_MOVE = 3'd1,
    CL_ALU  = 3'd2,
    CL_NOP  = 3'd3,
    CL_JMP  = 3'd4,
    CL_JNZ  = 3'd5
  } instr_class_t;

  function automatic logic is_nop(input logic [PM_W-1:0] op);
    return (op == OP_NOPC8) || (op == OP_NOPCF) ||
           (op == OP_NOPD8) || (op == OP_NOPDF);
  endfunction

  function automatic instr_class_t classify(input logic [PM_W-1:0] op);
    instr_class_t cls;
    cls = CL_LOAD;
    if (op[7]) begin
      if (!op[6]) begin
        cls = CL_MOVE;
      end else if (!op[5]) begin
        cls = is_nop(op) ? CL_NOP : CL_ALU;
      end
    end
    if (op[7:4] == OP_JMP) cls = CL_JMP;
    if (op[7:4] == OP_JNZ) cls = CL_JNZ;
    return cls;
  endfunction

endpackage

// File: rtl/instruction_decoder_if.sv
// Decoder bus: program-memory word and ALU zero in, sequencer and datapath
// controls out. Optional DEC_STATS_EN adds the instr_cnt / jmp_cnt counters.
interface instruction_decoder_if;
  import cpu_pkg::*;

  logic [PM_W-1:0]   pm_data;
  logic              alu_zero;
  logic              jmp;
  logic              jmp_nz;
  logic [ADDR_W-1:0] jmp_addr;
  logic              dont_jmp;
  logic              NOPC8;
  logic              NOPCF;
  logic              NOPD8;
  logic              NOPDF;
  logic [SEL_W-1:0]  src_sel;
  logic [SEL_W-1:0]  dst_sel;
  logic              reg_we;
  logic              alu_en;
  logic              dec_state;
`ifdef DEC_STATS_EN
  logic [15:0]       instr_cnt;
  logic [15:0]       jmp_cnt;
`endif

  // Decoder side
  modport slave (
    input  pm_data, alu_zero,
    output jmp, jmp_nz, jmp_addr, dont_jmp,
    output NOPC8, NOPCF, NOPD8, NOPDF,
    output src_sel, dst_sel, reg_we, alu_en, dec_state
`ifdef DEC_STATS_EN
    , output instr_cnt, jmp_cnt
`endif
  );

  // Program memory / sequencer / datapath side
  modport master (
    output pm_data, alu_zero,
    input  jmp, jmp_nz, jmp_addr, dont_jmp,
    input  NOPC8, NOPCF, NOPD8, NOPDF,
    input  src_sel, dst_sel, reg_we, alu_en, dec_state
`ifdef DEC_STATS_EN
    , input instr_cnt, jmp_cnt
`endif
  );

endinterface

// File: rtl/dec_stats_counter.sv
// Saturating up-counter for decoder statistics. Only built with DEC_STATS_EN.
`ifdef DEC_STATS_EN
module dec_stats_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles, sticking at all-ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/instruction_decoder.sv
// Instruction decoder: combinational decode of pm_data gated by a two-state
// FLUSH/RUN FSM, plus the registered zero flag feeding dont_jmp.
// Optional macro DEC_STATS_EN adds saturating instr_cnt / jmp_cnt counters.
//
// state | meaning
// FLUSH | first cycle after reset, pm_data not valid yet; outputs held at 0
// RUN   | pm_data decoded every cycle
module instruction_decoder
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  instruction_decoder_if.slave bus
);

  dec_state_t        state;
  dec_state_t        state_next;
  logic              z;

  logic              jmp_c;
  logic              jmp_nz_c;
  logic [ADDR_W-1:0] jmp_addr_c;
  logic [3:0]        nop_c;
  logic [SEL_W-1:0]  src_sel_c;
  logic [SEL_W-1:0]  dst_sel_c;
  logic              reg_we_c;
  logic              alu_en_c;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_FLUSH;
    end else begin
      state <= state_next;
    end
  end

  // Next state: leave FLUSH on the first edge, then stay in RUN
  always_comb begin
    state_next = state;
    case (state)
      ST_FLUSH: state_next = ST_RUN;
      ST_RUN:   state_next = ST_RUN;
      default:  state_next = ST_FLUSH;
    endcase
  end

  // Output decode; everything stays 0 while flushing. src/dst are only
  // meaningful for load/move, so they read 0 for every other class.
  always_comb begin
    jmp_c      = 1'b0;
    jmp_nz_c   = 1'b0;
    jmp_addr_c = '0;
    nop_c      = '0;
    src_sel_c  = '0;
    dst_sel_c  = '0;
    reg_we_c   = 1'b0;
    alu_en_c   = 1'b0;
    if (state == ST_RUN) begin
      jmp_addr_c = bus.pm_data[3:0];
      case (classify(bus.pm_data))
        CL_LOAD: begin
          reg_we_c  = 1'b1;
          dst_sel_c = bus.pm_data[6:4];
        end
        CL_MOVE: begin
          reg_we_c  = 1'b1;
          dst_sel_c = bus.pm_data[5:3];
          src_sel_c = bus.pm_data[2:0];
        end
        CL_ALU: alu_en_c = 1'b1;
        CL_NOP: begin
          nop_c[0] = (bus.pm_data == OP_NOPC8);
          nop_c[1] = (bus.pm_data == OP_NOPCF);
          nop_c[2] = (bus.pm_data == OP_NOPD8);
          nop_c[3] = (bus.pm_data == OP_NOPDF);
        end
        CL_JMP:  jmp_c    = 1'b1;
        CL_JNZ:  jmp_nz_c = 1'b1;
        default: ;
      endcase
    end
  end

  // Zero flag: captured only on ALU cycles, so a following jnz sees it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      z <= 1'b0;
    end else if (alu_en_c) begin
      z <= bus.alu_zero;
    end
  end

  assign bus.jmp       = jmp_c;
  assign bus.jmp_nz    = jmp_nz_c;
  assign bus.jmp_addr  = jmp_addr_c;
  assign bus.dont_jmp  = z;
  assign bus.NOPC8     = nop_c[0];
  assign bus.NOPCF     = nop_c[1];
  assign bus.NOPD8     = nop_c[2];
  assign bus.NOPDF     = nop_c[3];
  assign bus.src_sel   = src_sel_c;
  assign bus.dst_sel   = dst_sel_c;
  assign bus.reg_we    = reg_we_c;
  assign bus.alu_en    = alu_en_c;
  assign bus.dec_state = state;

`ifdef DEC_STATS_EN
  dec_stats_counter #(.W(16)) u_instr_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state == ST_RUN),
    .count   (bus.instr_cnt)
  );

  // A jump is counted when the sequencer will actually take it
  dec_stats_counter #(.W(16)) u_jmp_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (jmp_c | (jmp_nz_c & ~z)),
    .count   (bus.jmp_cnt)
  );
`endif

endmodule
